// File: rtl/mem_refill_ctrl_pkg.sv
// Shared definitions for the cache refill path: default geometry and the
// refill controller state encoding, used by the caches and the controller.
package mem_refill_ctrl_pkg;

    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB     = 3'd1,
        ST_FILL_I = 3'd2,
        ST_FILL_D = 3'd3,
        ST_COOL   = 3'd4
    } refill_state_e;

    // Word-index width within a line; a one-word line still gets a 1-bit index.
    function automatic int idx_width(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/mem_refill_ctrl_line_counter.sv
// Word index within the current line burst, plus a flag marking the last word.
module mem_refill_ctrl_line_counter
    import mem_refill_ctrl_pkg::*;
#(
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int IDX_W      = idx_width(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            // Power-of-two line: wrapping back to 0 after the last word is intended.
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_refill_ctrl.sv
// Shared I/D cache refill controller: dirty-line writeback and line fills
// against a single backing-memory port, with round-robin I/D miss arbitration.
module mem_refill_ctrl
    import mem_refill_ctrl_pkg::*;
#(
    parameter int  ADDR_W     = DEF_ADDR_W,
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  LINE_WORDS = DEF_LINE_WORDS,
    localparam int IDX_W      = idx_width(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_miss_req,
    input  logic [ADDR_W-1:0] i_miss_addr,
    output logic              i_fill_valid,
    output logic [ADDR_W-1:0] i_fill_addr,
    output logic [DATA_W-1:0] i_fill_data,
    output logic              i_ack,

    input  logic              d_miss_req,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wb_req,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [DATA_W-1:0] d_wb_data,
    output logic [IDX_W-1:0]  d_wb_idx,
    output logic              d_fill_valid,
    output logic [ADDR_W-1:0] d_fill_addr,
    output logic [DATA_W-1:0] d_fill_data,
    output logic              d_ack,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int TAG_W = ADDR_W - IDX_W;

    refill_state_e     state;
    logic [TAG_W-1:0]  line_tag;
    logic              last_served_d;
    logic [IDX_W-1:0]  cnt;
    logic              cnt_last;
    logic              busy;
    logic              word_done;
    logic              pick_d;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_lowbits;

    // Only the line part of a request address is kept; the low bits are
    // replaced by the burst counter, so a burst never carries into the next line.
    assign unused_lowbits = ^{i_miss_addr[IDX_W-1:0], d_miss_addr[IDX_W-1:0],
                              d_wb_addr[IDX_W-1:0]};

    assign busy      = (state == ST_WB) || (state == ST_FILL_I) || (state == ST_FILL_D);
    assign word_done = busy && mem_ready;
    assign word_addr = {line_tag, cnt};
    assign pick_d    = d_miss_req && (!i_miss_req || !last_served_d);

    mem_refill_ctrl_line_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_IDLE),
        .inc  (word_done),
        .cnt  (cnt),
        .last (cnt_last)
    );

    assign mem_req   = busy;
    assign mem_we    = (state == ST_WB);
    assign mem_addr  = busy ? word_addr : '0;
    assign mem_wdata = (state == ST_WB) ? d_wb_data : '0;
    assign d_wb_idx  = (state == ST_WB) ? cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            line_tag      <= '0;
            last_served_d <= 1'b0;
            i_fill_valid  <= 1'b0;
            i_fill_addr   <= '0;
            i_fill_data   <= '0;
            i_ack         <= 1'b0;
            d_fill_valid  <= 1'b0;
            d_fill_addr   <= '0;
            d_fill_data   <= '0;
            d_ack         <= 1'b0;
        end else begin
            i_fill_valid <= 1'b0;
            d_fill_valid <= 1'b0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_wb_req) begin
                        state    <= ST_WB;
                        line_tag <= d_wb_addr[ADDR_W-1:IDX_W];
                    end else if (pick_d) begin
                        state         <= ST_FILL_D;
                        line_tag      <= d_miss_addr[ADDR_W-1:IDX_W];
                        last_served_d <= 1'b1;
                    end else if (i_miss_req) begin
                        state         <= ST_FILL_I;
                        line_tag      <= i_miss_addr[ADDR_W-1:IDX_W];
                        last_served_d <= 1'b0;
                    end
                end
                ST_WB: begin
                    if (mem_ready && cnt_last) begin
                        // A pending D miss follows the eviction directly and owns the ack.
                        if (d_miss_req) begin
                            state         <= ST_FILL_D;
                            line_tag      <= d_miss_addr[ADDR_W-1:IDX_W];
                            last_served_d <= 1'b1;
                        end else begin
                            state <= ST_COOL;
                            d_ack <= 1'b1;
                        end
                    end
                end
                ST_FILL_I: begin
                    if (mem_ready) begin
                        i_fill_valid <= 1'b1;
                        i_fill_addr  <= word_addr;
                        i_fill_data  <= mem_rdata;
                        if (cnt_last) begin
                            i_ack <= 1'b1;
                            state <= ST_COOL;
                        end
                    end
                end
                ST_FILL_D: begin
                    if (mem_ready) begin
                        d_fill_valid <= 1'b1;
                        d_fill_addr  <= word_addr;
                        d_fill_data  <= mem_rdata;
                        if (cnt_last) begin
                            d_ack <= 1'b1;
                            state <= ST_COOL;
                        end
                    end
                end
                ST_COOL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl: fills, writeback+fill, arbitration,
// memory stalls, mid-burst reset and the top-of-memory line.
module tb_mem_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        i_miss_req;
    logic [14:0] i_miss_addr;
    logic        i_fill_valid;
    logic [14:0] i_fill_addr;
    logic [15:0] i_fill_data;
    logic        i_ack;
    logic        d_miss_req;
    logic [14:0] d_miss_addr;
    logic        d_wb_req;
    logic [14:0] d_wb_addr;
    logic [15:0] d_wb_data;
    logic [1:0]  d_wb_idx;
    logic        d_fill_valid;
    logic [14:0] d_fill_addr;
    logic [15:0] d_fill_data;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    logic [15:0] wb_line [4];
    int          n_cmp;
    int          n_fail;
    int          i_strobes;
    int          d_strobes;
    int          base_cnt;

    mem_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_miss_req   (i_miss_req),
        .i_miss_addr  (i_miss_addr),
        .i_fill_valid (i_fill_valid),
        .i_fill_addr  (i_fill_addr),
        .i_fill_data  (i_fill_data),
        .i_ack        (i_ack),
        .d_miss_req   (d_miss_req),
        .d_miss_addr  (d_miss_addr),
        .d_wb_req     (d_wb_req),
        .d_wb_addr    (d_wb_addr),
        .d_wb_data    (d_wb_data),
        .d_wb_idx     (d_wb_idx),
        .d_fill_valid (d_fill_valid),
        .d_fill_addr  (d_fill_addr),
        .d_fill_data  (d_fill_data),
        .d_ack        (d_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns address + 100; the D cache serves its dirty line by index.
    always_comb begin
        mem_rdata = {1'b0, mem_addr} + 16'd100;
        d_wb_data = wb_line[d_wb_idx];
    end

    always @(negedge clk) begin
        if (i_fill_valid) i_strobes++;
        if (d_fill_valid) d_strobes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_i(input string tag, input int a, input int d, input logic ack);
        check({tag, "_valid"}, 32'(i_fill_valid), 32'd1);
        check({tag, "_addr"}, 32'(i_fill_addr), 32'(a));
        check({tag, "_data"}, 32'(i_fill_data), 32'(d));
        check({tag, "_ack"}, 32'(i_ack), 32'(ack));
    endtask

    task automatic expect_d(input string tag, input int a, input int d, input logic ack);
        check({tag, "_valid"}, 32'(d_fill_valid), 32'd1);
        check({tag, "_addr"}, 32'(d_fill_addr), 32'(a));
        check({tag, "_data"}, 32'(d_fill_data), 32'(d));
        check({tag, "_ack"}, 32'(d_ack), 32'(ack));
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; i_strobes = 0; d_strobes = 0;
        rst = 1'b1;
        i_miss_req = 1'b0; i_miss_addr = '0;
        d_miss_req = 1'b0; d_miss_addr = '0;
        d_wb_req = 1'b0;   d_wb_addr = '0;
        mem_ready = 1'b1;
        wb_line[0] = 16'd77; wb_line[1] = 16'd78; wb_line[2] = 16'd79; wb_line[3] = 16'd80;

        // Reset state
        tick(); tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_wb_idx", 32'(d_wb_idx), 0);
        check("rst_i_valid", 32'(i_fill_valid), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        rst = 1'b0;
        tick();
        check("idle_mem_req", 32'(mem_req), 0);

        // I miss at 0x0005, zero-wait
        i_miss_req = 1'b1; i_miss_addr = 15'h0005;
        tick();
        check("t1_mem_req", 32'(mem_req), 1);
        check("t1_mem_we", 32'(mem_we), 0);
        check("t1_mem_addr0", 32'(mem_addr), 32'h0004);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_i($sformatf("t1_w%0d", k), 'h0004 + k, 104 + k, k == 3);
        end
        check("t1_cool_mem_req", 32'(mem_req), 0);
        i_miss_req = 1'b0;
        tick();
        check("t1_idle_valid", 32'(i_fill_valid), 0);
        check("t1_idle_ack", 32'(i_ack), 0);
        tick();
        check("t1_idle_mem_req", 32'(mem_req), 0);

        // Writeback then D fill of line 0x4008
        d_wb_req = 1'b1; d_wb_addr = 15'h4009;
        d_miss_req = 1'b1; d_miss_addr = 15'h4009;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_wb%0d_we", k), 32'(mem_we), 1);
            check($sformatf("t2_wb%0d_addr", k), 32'(mem_addr), 32'h4008 + k);
            check($sformatf("t2_wb%0d_idx", k), 32'(d_wb_idx), 32'(k));
            check($sformatf("t2_wb%0d_wdata", k), 32'(mem_wdata), 32'(77 + k));
            check($sformatf("t2_wb%0d_ack", k), 32'(d_ack), 0);
            tick();
        end
        d_wb_req = 1'b0;
        check("t2_fill_req", 32'(mem_req), 1);
        check("t2_fill_we", 32'(mem_we), 0);
        check("t2_fill_addr0", 32'(mem_addr), 32'h4008);
        check("t2_fill_idx", 32'(d_wb_idx), 0);
        check("t2_fill_ack", 32'(d_ack), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_d($sformatf("t2_f%0d", k), 'h4008 + k, 'h406C + k, k == 3);
        end
        d_miss_req = 1'b0;
        tick();
        check("t2_after_ack", 32'(d_ack), 0);
        check("t2_after_req", 32'(mem_req), 0);
        tick();

        // Simultaneous I/D misses, two rounds, after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_miss_req = 1'b1; i_miss_addr = 15'h0100;
        d_miss_req = 1'b1; d_miss_addr = 15'h0200;
        tick();
        check("t3_r1_first_d", 32'(mem_addr), 32'h0200);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_d($sformatf("t3_r1d%0d", k), 'h0200 + k, 'h0264 + k, k == 3);
        end
        d_miss_req = 1'b0;
        tick();
        check("t3_r1_cool_req", 32'(mem_req), 0);
        tick();
        check("t3_r1_then_i", 32'(mem_addr), 32'h0100);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_i($sformatf("t3_r1i%0d", k), 'h0100 + k, 'h0164 + k, k == 3);
        end
        i_miss_req = 1'b0;
        tick();
        i_miss_req = 1'b1; i_miss_addr = 15'h0300;
        d_miss_req = 1'b1; d_miss_addr = 15'h0400;
        tick();
        check("t3_r2_first_d", 32'(mem_addr), 32'h0400);
        for (int k = 0; k < 4; k++) tick();
        check("t3_r2_d_ack", 32'(d_ack), 1);
        d_miss_req = 1'b0;
        tick(); tick();
        check("t3_r2_then_i", 32'(mem_addr), 32'h0300);
        for (int k = 0; k < 4; k++) tick();
        expect_i("t3_r2i3", 'h0303, 'h0367, 1'b1);
        i_miss_req = 1'b0;
        tick();

        // Three stall cycles per word
        mem_ready = 1'b0;
        i_miss_req = 1'b1; i_miss_addr = 15'h1234;
        base_cnt = i_strobes;
        tick();
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 3; s++) begin
                tick();
                check($sformatf("t4_w%0d_s%0d_addr", w, s), 32'(mem_addr), 32'h1234 + w);
                check($sformatf("t4_w%0d_s%0d_we", w, s), 32'(mem_we), 0);
                check($sformatf("t4_w%0d_s%0d_req", w, s), 32'(mem_req), 1);
                check($sformatf("t4_w%0d_s%0d_valid", w, s), 32'(i_fill_valid), 0);
            end
            mem_ready = 1'b1;
            tick();
            expect_i($sformatf("t4_w%0d", w), 'h1234 + w, 'h1298 + w, w == 3);
            mem_ready = 1'b0;
        end
        i_miss_req = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("t4_strobe_count", 32'(i_strobes - base_cnt), 4);
        check("t4_cool_req", 32'(mem_req), 0);
        tick();

        // Reset after word 2 of a fill
        i_miss_req = 1'b1; i_miss_addr = 15'h2001;
        base_cnt = i_strobes;
        tick();
        tick(); tick(); tick();
        check("t5_w2_addr", 32'(i_fill_addr), 32'h2002);
        rst = 1'b1;
        tick();
        check("t5_rst_mem_req", 32'(mem_req), 0);
        check("t5_rst_mem_addr", 32'(mem_addr), 0);
        check("t5_rst_valid", 32'(i_fill_valid), 0);
        check("t5_rst_ack", 32'(i_ack), 0);
        check("t5_rst_faddr", 32'(i_fill_addr), 0);
        check("t5_rst_fdata", 32'(i_fill_data), 0);
        rst = 1'b0;
        tick();
        check("t5_restart_addr", 32'(mem_addr), 32'h2000);
        check("t5_no_extra_strobe", 32'(i_strobes - base_cnt), 3);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_i($sformatf("t5_w%0d", k), 'h2000 + k, 'h2064 + k, k == 3);
        end
        i_miss_req = 1'b0;
        tick(); tick();

        // Top line of the address space
        i_miss_req = 1'b1; i_miss_addr = 15'h7FFE;
        tick();
        check("t6_addr0", 32'(mem_addr), 32'h7FFC);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_i($sformatf("t6_w%0d", k), 'h7FFC + k, 'h8060 + k, k == 3);
        end
        check("t6_cool_addr", 32'(mem_addr), 0);
        i_miss_req = 1'b0;
        tick(); tick();
        check("t6_idle_req", 32'(mem_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
